cache_mem_arbiter: RTL and testbench

- Sits between the instruction cache, the data cache and the single RAM port.
- Grants the RAM to one cache at a time and holds the grant for the length of a block transfer.
- Returns per-requester wait/load signals.
- Data cache has fixed priority. A starvation counter guarantees instruction-fetch progress.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/arb_starve_cntr.sv | 27 ++
 rtl/cache_mem_arbiter.sv | 134 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, arbiter state encoding and owner encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } arb_state_t;

    localparam logic ARB_REQ_I = 1'b0;
    localparam logic ARB_REQ_D = 1'b1;

endpackage

// File: rtl/arb_starve_cntr.sv
// Saturating wait counter; clear wins over increment, flags when LIMIT is reached.
module arb_starve_cntr #(
    parameter int LIMIT = 8,
    localparam int W = $clog2(LIMIT + 1)
) (
    input  logic CLK,
    input  logic nRST,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    logic [W-1:0] r_count;

    assign o_at_limit = (r_count == W'(LIMIT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_count <= r_count + W'(1);
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single RAM port between icache and dcache, holding a grant for a block burst.
// Define ARB_RR_EN for round-robin arbitration in IDLE instead of fixed dcache priority.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int BURST_MAX    = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  iREN,
    input  word_t iaddr,
    output logic  iwait,
    output word_t iload,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output logic  dwait,
    output word_t dload,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  word_t ramload,
    input  logic  ramready
);

    localparam int BW = $clog2(BURST_MAX) + 1;

    arb_state_t r_state, w_next;
    logic [BW-1:0] r_beat;
    logic w_dReq, w_lastBeat, w_beatInc, w_atLimit, w_starveInc, w_starveClr;

    assign w_dReq      = dREN | dWEN;
    assign w_lastBeat  = (r_beat == BW'(BURST_MAX - 1));
    assign w_beatInc   = ramready && (((r_state == IGNT) && iREN) || ((r_state == DGNT) && w_dReq));
    assign w_starveInc = iREN && (r_state != IGNT);
    assign w_starveClr = !iREN || ((w_next == IGNT) && (r_state != IGNT));

    arb_starve_cntr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .CLK        (CLK),
        .nRST       (nRST),
        .i_inc      (w_starveInc),
        .i_clr      (w_starveClr),
        .o_at_limit (w_atLimit)
    );

`ifdef ARB_RR_EN
    logic r_lastOwner;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_lastOwner <= ARB_REQ_I;
        end else if (r_state == IDLE && w_next == IGNT) begin
            r_lastOwner <= ARB_REQ_I;
        end else if (r_state == IDLE && w_next == DGNT) begin
            r_lastOwner <= ARB_REQ_D;
        end
    end
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == IDLE) begin
                r_beat <= '0;
            end else if (w_beatInc) begin
                r_beat <= r_beat + BW'(1);
            end
        end
    end

    // Starvation override is checked first so icache always makes progress.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
`ifdef ARB_RR_EN
                if (w_atLimit && iREN)    w_next = IGNT;
                else if (w_dReq && iREN)  w_next = (r_lastOwner == ARB_REQ_D) ? IGNT : DGNT;
                else if (w_dReq)          w_next = DGNT;
                else if (iREN)            w_next = IGNT;
`else
                if (w_atLimit && iREN)    w_next = IGNT;
                else if (w_dReq)          w_next = DGNT;
                else if (iREN)            w_next = IGNT;
`endif
            end
            IGNT: if (!iREN || (ramready && w_lastBeat))   w_next = IDLE;
            DGNT: if (!w_dReq || (ramready && w_lastBeat)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        case (r_state)
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (iREN && ramready) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            DGNT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = dREN;
                end
                if (w_dReq && ramready) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter (default fixed-priority build).
module tb_cache_mem_arbiter;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  iREN, dREN, dWEN, ramready;
    word_t iaddr, daddr, dstore, ramload;
    logic  iwait, dwait, ramREN, ramWEN;
    word_t iload, dload, ramaddr, ramstore;

    int passCount  = 0;
    int totalCount = 0;

    typedef struct {
        logic  iREN, dREN, dWEN, ramready;
        word_t iaddr, daddr, dstore, ramload;
        logic  eRamREN, eRamWEN, eIwait, eDwait;
        word_t eRamaddr, eRamstore, eIload, eDload;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[17];

    cache_mem_arbiter dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dwait    (dwait),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramready (ramready)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(logic ir, logic dr, logic dw, logic rdy,
                                word_t ia, word_t da, word_t ds, word_t rl,
                                logic eRen, logic eWen, word_t eAddr, word_t eStore,
                                logic eIw, logic eDw, word_t eIl, word_t eDl);
        vec_t v;
        v.iREN = ir;  v.dREN = dr;  v.dWEN = dw;  v.ramready = rdy;
        v.iaddr = ia; v.daddr = da; v.dstore = ds; v.ramload = rl;
        v.eRamREN = eRen; v.eRamWEN = eWen; v.eRamaddr = eAddr; v.eRamstore = eStore;
        v.eIwait = eIw;   v.eDwait = eDw;   v.eIload = eIl;     v.eDload = eDl;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Drive one cycle's inputs at the falling edge and queue its expected outputs.
    task automatic applyStimulus(input vec_t v);
        @(negedge CLK);
        iREN = v.iREN; dREN = v.dREN; dWEN = v.dWEN; ramready = v.ramready;
        iaddr = v.iaddr; daddr = v.daddr; dstore = v.dstore; ramload = v.ramload;
        sb.push_back(v);
    endtask

    task automatic checkOutput(input string tag);
        vec_t e;
        #1;
        if (sb.size() == 0) begin
            checkField({tag, ".scoreboardEmpty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        checkField({tag, ".ramREN"},   {31'd0, ramREN}, {31'd0, e.eRamREN});
        checkField({tag, ".ramWEN"},   {31'd0, ramWEN}, {31'd0, e.eRamWEN});
        checkField({tag, ".ramaddr"},  ramaddr,         e.eRamaddr);
        checkField({tag, ".ramstore"}, ramstore,        e.eRamstore);
        checkField({tag, ".iwait"},    {31'd0, iwait},  {31'd0, e.eIwait});
        checkField({tag, ".dwait"},    {31'd0, dwait},  {31'd0, e.eDwait});
        checkField({tag, ".iload"},    iload,           e.eIload);
        checkField({tag, ".dload"},    dload,           e.eDload);
    endtask

    function automatic vec_t idleVec();
        return mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1,1,0,0);
    endfunction

    initial begin
        int found;
        word_t L;
        L = 32'hDEADBEEF;

        // Per-cycle vectors starting from IDLE after reset.
        tbl[0]  = mk(1,0,0,0, 32'h40,0,0,L,            0,0,0,0,              1,1,0,0);
        tbl[1]  = mk(1,0,0,0, 32'h40,0,0,L,            1,0,32'h40,0,         1,1,0,0);
        tbl[2]  = mk(1,0,0,0, 32'h40,0,0,L,            1,0,32'h40,0,         1,1,0,0);
        tbl[3]  = mk(1,0,0,1, 32'h40,0,0,L,            1,0,32'h40,0,         0,1,L,0);
        tbl[4]  = mk(0,0,0,0, 32'h40,0,0,L,            0,0,32'h40,0,         1,1,0,0);
        tbl[5]  = mk(0,0,0,0, 0,0,0,L,                 0,0,0,0,              1,1,0,0);
        tbl[6]  = mk(1,1,0,0, 32'h80,32'h200,0,32'h1234, 0,0,0,0,            1,1,0,0);
        tbl[7]  = mk(1,1,0,0, 32'h80,32'h200,0,32'h1234, 1,0,32'h200,0,      1,1,0,0);
        tbl[8]  = mk(1,1,0,1, 32'h80,32'h200,0,32'h1234, 1,0,32'h200,0,      1,0,0,32'h1234);
        tbl[9]  = mk(1,0,0,0, 32'h80,32'h200,0,32'h1234, 0,0,32'h200,0,      1,1,0,0);
        tbl[10] = mk(1,0,0,0, 32'h80,0,0,32'h1234,     0,0,0,0,              1,1,0,0);
        tbl[11] = mk(1,0,0,0, 32'h80,0,0,32'h1234,     1,0,32'h80,0,         1,1,0,0);
        tbl[12] = mk(0,0,0,0, 32'h80,0,0,32'h1234,     0,0,32'h80,0,         1,1,0,0);
        tbl[13] = mk(0,1,1,0, 0,32'h300,32'h55,0,      0,0,0,0,              1,1,0,0);
        tbl[14] = mk(0,1,1,0, 0,32'h300,32'h55,0,      0,1,32'h300,32'h55,   1,1,0,0);
        tbl[15] = mk(0,0,0,0, 0,32'h300,32'h55,0,      0,0,32'h300,0,        1,1,0,0);
        tbl[16] = idleVec();

        // Reset state with requests active: arbiter must stay quiet.
        nRST = 1'b0;
        applyStimulus(mk(1,1,1,1, 32'h40,32'h100,32'h77,L, 0,0,0,0, 1,1,0,0));
        checkOutput("reset");
        checkField("reset.beat",   {30'd0, dut.r_beat},           32'd0);
        checkField("reset.starve", {28'd0, dut.u_starve.r_count}, 32'd0);
        applyStimulus(idleVec());
        nRST = 1'b1;
        checkOutput("resetRelease");

        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // Two-beat write burst ends the grant even though dWEN is still held.
        applyStimulus(mk(0,0,1,0, 0,32'h100,32'h11,0, 0,0,0,0,               1,1,0,0));
        checkOutput("burst.c0");
        applyStimulus(mk(0,0,1,1, 0,32'h100,32'h11,0, 0,1,32'h100,32'h11,    1,0,0,0));
        checkOutput("burst.c1");
        applyStimulus(mk(0,0,1,1, 0,32'h104,32'h22,0, 0,1,32'h104,32'h22,    1,0,0,0));
        checkOutput("burst.c2");
        checkField("burst.beatLast", {30'd0, dut.r_beat}, 32'd1);
        applyStimulus(mk(0,0,1,0, 0,32'h108,32'h33,0, 0,0,0,0,               1,1,0,0));
        checkOutput("burst.c3");
        checkField("burst.beatCleared", {30'd0, dut.r_beat}, 32'd0);
        applyStimulus(idleVec());
        checkOutput("burst.c4");
        applyStimulus(idleVec());
        checkOutput("burst.c5");

        // Starvation: dcache bursts back to back; icache must win once it has waited
        // STARVE_LIMIT cycles, i.e. on the 11th cycle (index 10) of continuous requests.
        found = -1;
        for (int k = 0; k < 30 && found < 0; k++) begin
            @(negedge CLK);
            iREN = 1; dREN = 1; dWEN = 0; ramready = 1;
            iaddr = 32'h44; daddr = 32'h500; ramload = 32'hA5A5A5A5;
            #1;
            if (ramREN && ramaddr == 32'h44) begin
                found = k;
                checkField("starve.countAfterGrant", {28'd0, dut.u_starve.r_count}, 32'd0);
                checkField("starve.dwaitNonOwner", {31'd0, dwait}, 32'd1);
            end
        end
        checkField("starve.grantCycle", found, 32'd10);
        applyStimulus(idleVec());
        checkOutput("starve.release");
        applyStimulus(idleVec());
        checkOutput("starve.idle");

        // Asynchronous reset during a dcache write drops the strobe immediately.
        applyStimulus(mk(1,0,1,0, 0,32'h600,32'h99,0, 0,0,0,0,              1,1,0,0));
        checkOutput("rst.c0");
        applyStimulus(mk(1,0,1,0, 0,32'h600,32'h99,0, 0,1,32'h600,32'h99,   1,1,0,0));
        checkOutput("rst.c1");
        #2;
        nRST = 1'b0;
        #1;
        checkField("rst.ramWENDrop",   {31'd0, ramWEN}, 32'd0);
        checkField("rst.ramaddrDrop",  ramaddr,         32'd0);
        checkField("rst.ramstoreDrop", ramstore,        32'd0);
        applyStimulus(idleVec());
        nRST = 1'b1;
        checkOutput("rst.release");
        checkField("rst.beat",   {30'd0, dut.r_beat},           32'd0);
        checkField("rst.starve", {28'd0, dut.u_starve.r_count}, 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
